// File: rtl/owl_sfr_bank.sv
// SFR bank behind the one-wire link controller: chip ID, status mirror, event flags,
// interrupt enables, control register and 24 key-protected trim registers.
module owl_sfr_bank #(
    parameter logic [7:0]  CHIP_ID  = 8'h52,
    parameter int unsigned TMO_W    = 16,
    parameter logic [7:0]  TRIM_RST = 8'h00
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   sfr_addrs,
    input  logic [7:0]   sfr_wdata,
    input  logic         sfr_wctrl,
    input  logic         sfr_rctrl,
    output logic         sfr_ready,
    output logic [7:0]   sfr_rdata,
    input  logic [7:0]   status_in,
    input  logic [6:0]   event_in,
    output logic [7:0]   ctrl_out,
    output logic [191:0] trim_out,
    output logic         irq,
    output logic         unlocked
);

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        KEY1     = 2'd1,
        UNLOCKED = 2'd2
    } lock_e;

    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

    lock_e              state_q, state_d;
    logic [TMO_W-1:0]   cnt_q, cnt_d;
    logic [23:0][7:0]   trim_q;
    logic [7:0]         flags_q, flags_d;
    logic [7:0]         en_q, ctrl_q, status_q, rdata_q, rdata_d;
    logic [6:0]         event_q;
    logic [5:0]         addr_q;
    logic               rctrl_q, ready_q, irq_q;

    logic               key_hit, trim_hit, trim_wr_ok;
    logic [4:0]         trim_idx;

    assign key_hit    = (sfr_addrs == 6'h04);
    assign trim_hit   = (sfr_addrs[5] == 1'b0) && (sfr_addrs[4:3] != 2'b00);
    assign trim_idx   = sfr_addrs[4:0] - 5'd8;
    assign trim_wr_ok = sfr_wctrl && trim_hit && (state_q == UNLOCKED);

    // Event set is applied after the W1C mask so a coincident rising edge wins.
    always_comb begin
        flags_d = flags_q;
        if (sfr_wctrl && sfr_addrs == 6'h02) begin
            flags_d = flags_q & ~sfr_wdata;
        end
        flags_d[6:0] = flags_d[6:0] | (event_in & ~event_q);
        if (sfr_wctrl && trim_hit && state_q != UNLOCKED) begin
            flags_d[7] = 1'b1;
        end
    end

    // Relock fires on the edge where the counter would become all-ones, even with a write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOCKED: begin
                if (sfr_wctrl && key_hit && sfr_wdata == 8'hA5) state_d = KEY1;
            end
            KEY1: begin
                if (sfr_wctrl) state_d = (key_hit && sfr_wdata == 8'h5A) ? UNLOCKED : LOCKED;
            end
            UNLOCKED: begin
                if ((sfr_wctrl && key_hit) || cnt_q == TMO_LAST) state_d = LOCKED;
            end
            default: state_d = LOCKED;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != UNLOCKED || sfr_wctrl) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + TMO_ONE;
        end
    end

    always_comb begin
        rdata_d = '0;
        if (trim_hit) begin
            rdata_d = trim_q[trim_idx];
        end else begin
            case (sfr_addrs)
                6'h00:   rdata_d = CHIP_ID;
                6'h01:   rdata_d = status_q;
                6'h02:   rdata_d = flags_q;
                6'h03:   rdata_d = en_q;
                6'h04:   rdata_d = {7'b0, unlocked};
                6'h05:   rdata_d = ctrl_q;
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= LOCKED;
            cnt_q    <= '0;
            trim_q   <= {24{TRIM_RST}};
            flags_q  <= '0;
            en_q     <= '0;
            ctrl_q   <= '0;
            status_q <= '0;
            event_q  <= '0;
            addr_q   <= '0;
            rctrl_q  <= 1'b0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            flags_q  <= flags_d;
            status_q <= status_in;
            event_q  <= event_in;
            addr_q   <= sfr_addrs;
            rctrl_q  <= sfr_rctrl;
            ready_q  <= sfr_rctrl && rctrl_q && (sfr_addrs == addr_q);
            rdata_q  <= rdata_d;
            irq_q    <= |(flags_q & en_q);
            if (sfr_wctrl && sfr_addrs == 6'h03) en_q <= sfr_wdata;
            if (sfr_wctrl && sfr_addrs == 6'h05) ctrl_q <= sfr_wdata;
            if (trim_wr_ok) trim_q[trim_idx] <= sfr_wdata;
        end
    end

    assign sfr_ready = ready_q;
    assign sfr_rdata = rdata_q;
    assign ctrl_out  = ctrl_q;
    assign trim_out  = trim_q;
    assign irq       = irq_q;
    assign unlocked  = (state_q == UNLOCKED);

endmodule
